// File: rtl/cpu_defs_pkg.sv
// ============================================================================
// Module      : cpu_defs_pkg
// Description : Shared CPU definitions: default widths, opcodes, the
//               fetch sequencer state encoding and the NOP instruction word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_defs_pkg;

    // Default widths used by the fetch path
    localparam int DEF_ADDR_W  = 10;
    localparam int DEF_INSTR_W = 16;
    localparam int DEF_OPC_W   = 6;

    // Opcode that decode treats as "do nothing"
    localparam logic [DEF_OPC_W-1:0] OP_NOP = 6'h00;

    // Canonical NOP word: NOP opcode with an all-zero operand field
    localparam logic [DEF_INSTR_W-1:0] c_NOP_INSTR =
        {OP_NOP, {(DEF_INSTR_W-DEF_OPC_W){1'b0}}};

    // Fetch sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_t;

endpackage : cpu_defs_pkg

`default_nettype wire

// File: rtl/fetch_pc_next.sv
// ============================================================================
// Module      : fetch_pc_next
// Description : Combinational next-address logic for the fetch sequencer:
//               branch target computation, ROM address priority mux and the
//               sequential +1 increment of the selected address.
//               Macro FETCH_REL_BRANCH_EN selects PC-relative branches
//               (Branch_pc + sign-extended 7-bit offset); when undefined the
//               branch target is taken as an absolute address.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_pc_next
    import cpu_defs_pkg::*;
#(
    parameter int                ADDR_W     = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
    input  fetch_state_t      i_state,
    input  logic              i_halt,
    input  logic              i_branch_take,
    input  logic              i_stall,
    input  logic [ADDR_W-1:0] i_branch_target,
    input  logic [ADDR_W-1:0] i_branch_pc,
    input  logic [ADDR_W-1:0] i_pc,
    input  logic [ADDR_W-1:0] i_fetch_pc,
    output logic [ADDR_W-1:0] o_rom_ip,
    output logic [ADDR_W-1:0] o_rom_ip_inc
);

    logic [ADDR_W-1:0] w_target;

`ifdef FETCH_REL_BRANCH_EN
    // Relative redirect: 7-bit signed offset from the branch instruction,
    // wrapping modulo the address space.
    logic [ADDR_W-1:0] w_offset;
    logic              w_unused_target_hi;

    assign w_offset           = {{(ADDR_W-7){i_branch_target[6]}}, i_branch_target[6:0]};
    assign w_target           = i_branch_pc + w_offset;
    assign w_unused_target_hi = ^i_branch_target[ADDR_W-1:7];
`else
    // Absolute redirect: the branch pc plays no part
    logic w_unused_branch_pc;

    assign w_target           = i_branch_target;
    assign w_unused_branch_pc = ^i_branch_pc;
`endif

    // ROM address priority: not running > halt > branch > stall replay > advance
    always_comb begin
        o_rom_ip = i_pc;
        if (i_state != ST_RUN) begin
            o_rom_ip = RESET_ADDR;
        end else if (i_halt) begin
            o_rom_ip = i_pc;
        end else if (i_branch_take) begin
            o_rom_ip = w_target;
        end else if (i_stall) begin
            // Re-read the held word so the ROM keeps presenting it
            o_rom_ip = i_fetch_pc;
        end
    end

    // The word fetched now sits at o_rom_ip; the one after it is +1 (wraps)
    assign o_rom_ip_inc = o_rom_ip + ADDR_W'(1);

endmodule : fetch_pc_next

`default_nettype wire

// File: rtl/fetch_ctrl.sv
// ============================================================================
// Module      : fetch_ctrl
// Description : Instruction-fetch sequencer between decode and a synchronous
//               instruction ROM. Owns the program counter, tracks which
//               address the ROM output belongs to, and handles start/halt,
//               decode stalls (address replay) and zero-bubble branches.
//               Macro FETCH_REL_BRANCH_EN enables PC-relative branch targets.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_ctrl
    import cpu_defs_pkg::*;
#(
    parameter int                ADDR_W     = DEF_ADDR_W,
    parameter int                INSTR_W    = DEF_INSTR_W,
    parameter int                OPC_W      = DEF_OPC_W,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
    input  logic               Clock,
    input  logic               Reset_n,
    input  logic               Start,
    input  logic               Halt,
    input  logic               Stall,
    input  logic               Branch_take,
    input  logic [ADDR_W-1:0]  Branch_target,
    input  logic [ADDR_W-1:0]  Branch_pc,
    output logic [ADDR_W-1:0]  Rom_Ip,
    input  logic [INSTR_W-1:0] Rom_Instr,
    output logic [INSTR_W-1:0] Instr_out,
    output logic               Instr_valid,
    output logic [ADDR_W-1:0]  Instr_pc,
    output logic               Busy
);

    // NOP sized to this instance's instruction width
    localparam logic [INSTR_W-1:0] c_NOP_WORD =
        {OPC_W'(OP_NOP), {(INSTR_W-OPC_W){1'b0}}};

    fetch_state_t      r_state;
    logic [ADDR_W-1:0] r_pc;        // next sequential address to fetch
    logic [ADDR_W-1:0] r_fetch_pc;  // address of the word on Rom_Instr
    logic              r_rom_vld;   // Rom_Instr carries a real fetched word
    logic              r_busy;

    logic [ADDR_W-1:0] w_rom_ip;
    logic [ADDR_W-1:0] w_rom_ip_inc;

    fetch_pc_next #(
        .ADDR_W     (ADDR_W),
        .RESET_ADDR (RESET_ADDR)
    ) u_pc_next (
        .i_state         (r_state),
        .i_halt          (Halt),
        .i_branch_take   (Branch_take),
        .i_stall         (Stall),
        .i_branch_target (Branch_target),
        .i_branch_pc     (Branch_pc),
        .i_pc            (r_pc),
        .i_fetch_pc      (r_fetch_pc),
        .o_rom_ip        (w_rom_ip),
        .o_rom_ip_inc    (w_rom_ip_inc)
    );

    // Fetch FSM: whatever address goes to the ROM this cycle becomes the
    // tracked fetch address, and its successor becomes the next pc.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state    <= ST_IDLE;
            r_pc       <= RESET_ADDR;
            r_fetch_pc <= RESET_ADDR;
            r_rom_vld  <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (Halt) begin
                        r_state   <= ST_HALT;
                        r_rom_vld <= 1'b0;
                        r_busy    <= 1'b0;
                    end else if (Branch_take || !Stall) begin
                        // Redirect or sequential advance; a stall without a
                        // branch holds everything so the word is replayed.
                        r_fetch_pc <= w_rom_ip;
                        r_pc       <= w_rom_ip_inc;
                        r_rom_vld  <= 1'b1;
                    end
                end
                default: begin
                    // IDLE and HALT behave the same: wait for Start
                    if (Start) begin
                        r_state    <= ST_RUN;
                        r_busy     <= 1'b1;
                        r_fetch_pc <= w_rom_ip;
                        r_pc       <= w_rom_ip_inc;
                        r_rom_vld  <= 1'b1;
                    end else begin
                        r_rom_vld  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign Rom_Ip      = w_rom_ip;
    assign Instr_valid = r_rom_vld;
    assign Instr_out   = r_rom_vld ? Rom_Instr : c_NOP_WORD;
    assign Instr_pc    = r_fetch_pc;
    assign Busy        = r_busy;

endmodule : fetch_ctrl

`default_nettype wire

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer between the core's decode stage and the synchronous instruction ROM (10-bit `Ip` in, 16-bit `Instr` out, registered on the rising clock edge).
- It owns the program counter and drives the ROM address.
- It tracks which address the ROM word on its output belongs to, and presents that word to decode with a valid flag.
- It handles start/halt, decode stalls (address replay) and taken branches (zero-bubble redirect).

## Interface
- `ADDR_W`, 10: instruction address width.
- `INSTR_W`, 16: instruction word width.
- `OPC_W`, 6: opcode field width (`Instr[15:10]`).
- `RESET_ADDR`, 0: program start address after reset, Start and restart.
- `Clock` in 1: single clock, rising edge.
- `Reset_n` in 1: reset, asynchronous, active-low.
- `Start` in 1: level-sampled; leaves IDLE/HALT and begins fetching at `RESET_ADDR`.
- `Halt` in 1: level-sampled; stops fetching.
- `Stall` in 1: decode is not consuming; hold the current instruction.
- `Branch_take` in 1: single-cycle redirect request from execute.
- `Branch_target` in ADDR_W: absolute target, or `[6:0]` signed offset with the macro below.
- `Branch_pc` in ADDR_W: address of the branch instruction; used only with the macro.
- `Rom_Ip` out ADDR_W: ROM address, combinational.
- `Rom_Instr` in INSTR_W: ROM data, valid one edge after `Rom_Ip` is sampled.
- `Instr_out` out INSTR_W: instruction to decode; equals NOP when not valid.
- `Instr_valid` out 1: `Instr_out` is a real fetched word.
- `Instr_pc` out ADDR_W: address of `Instr_out`.
- `Busy` out 1: state is RUN.

## Operation
- Registers:
  - `state_q` (IDLE, RUN, HALT).
  - `pc_q`: next address to fetch.
  - `fetch_pc_q`: address of the word currently on `Rom_Instr`.
  - `rom_vld_q`.
- Reset values:
  - `state_q`=IDLE, `pc_q`=`fetch_pc_q`=`RESET_ADDR`, `rom_vld_q`=0.
  - Hence `Rom_Ip`=`RESET_ADDR`, `Instr_out`=NOP ({OP_NOP, 10'h0}), `Instr_valid`=0, `Instr_pc`=`RESET_ADDR`, `Busy`=0.
- Combinational outputs:
  - `Instr_valid`=`rom_vld_q`.
  - `Instr_out`=`rom_vld_q` ? `Rom_Instr` : NOP.
  - `Instr_pc`=`fetch_pc_q`.
- `Rom_Ip` selection, highest priority first:
  - IDLE/HALT → `RESET_ADDR`.
  - RUN & `Halt` → `pc_q` (don't care).
  - RUN & `Branch_take` → computed target.
  - RUN & `Stall` → `fetch_pc_q` (replay, so the ROM re-presents the held word).
  - else `pc_q`.
- IDLE/HALT:
  - With `Start`=1 at an edge: state→RUN, `fetch_pc_q`←`RESET_ADDR`, `pc_q`←`RESET_ADDR`+1, `rom_vld_q`←1.
  - Otherwise all registers hold, with `rom_vld_q`=0.
- RUN, priority Halt > Branch > Stall > advance:
  - Halt: state→HALT, `rom_vld_q`←0.
  - Branch: `fetch_pc_q`←T, `pc_q`←T+1, `rom_vld_q`←1. The in-flight sequential word is discarded. `Stall` is ignored that cycle, and decode must drop its held word.
  - Stall: all registers hold.
  - Advance: `fetch_pc_q`←`pc_q`, `pc_q`←`pc_q`+1.
- Arithmetic: all address arithmetic is modulo 2^ADDR_W, so 1023+1 wraps to 0 with no flag.
- `Start` while in RUN is ignored.
- `Reset_n` low at any time forces reset values immediately; no ROM access state survives.

## Timing
- Fetch latency is one cycle: an address on `Rom_Ip` at edge N gives `Instr_out` valid during cycle N→N+1.
- Start: `Instr_valid` rises one edge after the `Start` edge, with `Instr_pc`=`RESET_ADDR`.
- Branch: zero fetch bubbles. The target word is valid the cycle immediately after the `Branch_take` edge. Delay slots already in decode remain software's job (NOP padding).
- Stall: `Instr_out`/`Instr_pc` are stable for every stalled cycle, and the stream resumes with no loss or duplication the cycle after `Stall` falls.
- Halt: `Instr_valid` falls one edge after the `Halt` edge.

## Configuration
- `FETCH_REL_BRANCH_EN`:
  - Defined: T = `Branch_pc` + sign-extend(`Branch_target[6:0]`), mod 2^ADDR_W.
  - Undefined: T = `Branch_target`, absolute; `Branch_pc` is unused.

## Structure
- Shared package `cpu_defs_pkg`:
  - `OP_NOP` (6'h00), `ADDR_W`/`INSTR_W`/`OPC_W` defaults.
  - The `fetch_state_t` enum, and the NOP word constant.
- One sub-module, `fetch_pc_next`, is natural. It is purely combinational: target computation (both macro variants), the +1 increment and the `Rom_Ip` priority mux.
- `fetch_ctrl` keeps the FSM and registers.

## Test plan
- Reset, then Start at cycle 3: `Rom_Ip` = 0,1,2,3… on consecutive edges; `Instr_valid` rises the cycle after Start with `Instr_pc` = 0, 1, 2; `Busy`=1.
- Stall for 3 cycles while `Instr_pc`=5: `Rom_Ip`=5 throughout; `Instr_out` is constant (word 5); after release `Instr_pc` = 6, 7.
- Branch at `Instr_pc`=16:
  - Absolute, `Branch_target`=0x00D: next `Instr_pc` = 13, then 14. Stall asserted in the same cycle is ignored.
  - With the macro, `Branch_pc`=16 and offset 7'h7D (−3): next `Instr_pc`=13.
- Wrap: run to address 1023 → next `Instr_pc`=0, `Instr_valid` stays 1.
- Halt at `Instr_pc`=8 with Branch also asserted: Halt wins, `Instr_valid`=0, `Instr_out`=NOP. Start then restarts at 0.
- `Reset_n` pulsed low mid-RUN (between edges): outputs go to reset values asynchronously; state is IDLE and no further fetch occurs until Start.
